// File: rtl/crc32_par.sv
// Word-wide CRC-32 (IEEE 802.3 / PNG) engine folding BYTES_PER_CYC bytes per clock.
// Define CRC32_PAR_SEED_EN to add seed_i for continuing a CRC from a prior dat_o.
module crc32_par #(
    parameter int unsigned DATA_WD       = 32,
    parameter int unsigned BYTES_PER_CYC = 1,
    parameter int unsigned NB_WD         = $clog2(DATA_WD / 8) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
`ifdef CRC32_PAR_SEED_EN
    input  logic [31:0]        seed_i,
`endif
    input  logic               val_i,
    output logic               rdy_o,
    input  logic [DATA_WD-1:0] dat_i,
    input  logic               lst_i,
    input  logic [NB_WD-1:0]   nb_i,
    output logic               done_o,
    output logic               val_o,
    output logic [31:0]        dat_o
);
    localparam int unsigned NBytes = DATA_WD / 8;
    localparam logic [31:0] Poly   = 32'hEDB88320;

    typedef enum logic [1:0] {StIdle, StActv, StProc, StDone} state_e;

    state_e             state_q;
    logic [31:0]        crc_q, crc_d, seed;
    logic [DATA_WD-1:0] buf_q;
    logic [NB_WD-1:0]   nb_q, nb_in, cnt_q;
    logic               last_q, last_slice;
    logic               rdy_q, done_q, val_q;
    logic [31:0]        dat_q;
    int unsigned        idx;

    // Reflected update: byte enters LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ Poly) : (r >> 1);
        end
        return r;
    endfunction

`ifdef CRC32_PAR_SEED_EN
    assign seed = ~seed_i;
`else
    assign seed = 32'hFFFFFFFF;
`endif

    always_comb begin
        if (!lst_i || nb_i == '0 || 32'(nb_i) > NBytes) begin
            nb_in = NB_WD'(NBytes);
        end else begin
            nb_in = nb_i;
        end
    end

    // Chain of byte stages for the current slice; stages past nb pass the state through.
    always_comb begin
        crc_d = crc_q;
        idx   = 0;
        for (int unsigned k = 0; k < BYTES_PER_CYC; k++) begin
            idx = 32'(cnt_q) * BYTES_PER_CYC + k;
            if (idx < 32'(nb_q)) begin
                crc_d = crc_byte(crc_d, buf_q[8*(NBytes-1-idx) +: 8]);
            end
        end
        last_slice = (32'(cnt_q) + 1) * BYTES_PER_CYC >= 32'(nb_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            crc_q   <= 32'hFFFFFFFF;
            buf_q   <= '0;
            nb_q    <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            val_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                state_q <= StActv;
                crc_q   <= seed;
                cnt_q   <= '0;
                rdy_q   <= 1'b1;
                val_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StActv: begin
                        if (val_i) begin
                            buf_q   <= dat_i;
                            nb_q    <= nb_in;
                            last_q  <= lst_i;
                            cnt_q   <= '0;
                            rdy_q   <= 1'b0;
                            state_q <= StProc;
                        end
                    end
                    StProc: begin
                        crc_q <= crc_d;
                        cnt_q <= cnt_q + NB_WD'(1);
                        if (last_slice) begin
                            if (last_q) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= StActv;
                                rdy_q   <= 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        dat_q   <= ~crc_q;
                        val_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign rdy_o  = rdy_q;
    assign done_o = done_q;
    assign val_o  = val_q;
    assign dat_o  = dat_q;
endmodule

// File: tb/tb_crc32_par.sv
// Directed bench for crc32_par: one instance with 1 byte/clock, one with 4 bytes/clock.
module tb_crc32_par;
    logic        clk = 1'b0;
    logic        rst, start1, start4, val1, val4, lst;
    logic [31:0] dat, seed;
    logic [2:0]  nb;
    logic        rdy1, done1, vo1, rdy4, done4, vo4;
    logic [31:0] do1, do4;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    crc32_par #(.DATA_WD(32), .BYTES_PER_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start1),
`ifdef CRC32_PAR_SEED_EN
        .seed_i(seed),
`endif
        .val_i(val1), .rdy_o(rdy1), .dat_i(dat), .lst_i(lst), .nb_i(nb),
        .done_o(done1), .val_o(vo1), .dat_o(do1)
    );

    crc32_par #(.DATA_WD(32), .BYTES_PER_CYC(4)) u_dut4 (
        .clk(clk), .rst(rst), .start_i(start4),
`ifdef CRC32_PAR_SEED_EN
        .seed_i(seed),
`endif
        .val_i(val4), .rdy_o(rdy4), .dat_i(dat), .lst_i(lst), .nb_i(nb),
        .done_o(done4), .val_o(vo4), .dat_o(do4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input bit sel4);
        if (sel4) start4 = 1'b1; else start1 = 1'b1;
        tick();
        start1 = 1'b0;
        start4 = 1'b0;
    endtask

    // Returns in the first cycle after the accepting edge; inputs are then scrambled.
    task automatic send(input bit sel4, input logic [31:0] d, input logic l, input logic [2:0] n);
        logic r, acc;
        dat = d; lst = l; nb = n;
        if (sel4) val4 = 1'b1; else val1 = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            r = sel4 ? rdy4 : rdy1;
            tick();
            acc = r;
        end
        val1 = 1'b0; val4 = 1'b0;
        dat = 32'hDEADBEEF; lst = 1'b1; nb = 3'd2;
        chk("accept", {31'b0, acc}, 32'd1);
    endtask

    task automatic wait_done(input bit sel4);
        logic seen;
        seen = sel4 ? done4 : done1;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            seen = sel4 ? done4 : done1;
        end
        chk("done_seen", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w[3];
        int          acc_cyc[3];
        int          nacc, ndone;
        logic        r;

        rst = 1'b1; start1 = 0; start4 = 0; val1 = 0; val4 = 0;
        lst = 0; dat = '0; nb = '0; seed = '0;
        tick(); tick();
        rst = 1'b0;
        chk("reset_rdy1", {31'b0, rdy1}, 32'd0);
        chk("reset_done1", {31'b0, done1}, 32'd0);
        chk("reset_val1", {31'b0, vo1}, 32'd0);
        chk("reset_dat1", do1, 32'h0);
        chk("reset_rdy4", {31'b0, rdy4}, 32'd0);

        // "123456789", one byte per clock
        start(1'b0);
        chk("start_rdy1", {31'b0, rdy1}, 32'd1);
        send(1'b0, 32'h31323334, 1'b0, 3'd4);
        send(1'b0, 32'h35363738, 1'b0, 3'd4);
        send(1'b0, 32'h39000000, 1'b1, 3'd1);
        chk("b1_no_done_yet", {31'b0, done1}, 32'd0);
        tick();
        chk("b1_done_pulse", {31'b0, done1}, 32'd1);
        chk("b1_val_in_done", {31'b0, vo1}, 32'd0);
        tick();
        chk("b1_done_cleared", {31'b0, done1}, 32'd0);
        chk("b1_val", {31'b0, vo1}, 32'd1);
        chk("b1_crc", do1, 32'hCBF43926);
        chk("b1_idle_rdy", {31'b0, rdy1}, 32'd0);

        // "IEND", four bytes per clock: done two cycles after accept
        start(1'b1);
        send(1'b1, 32'h49454E44, 1'b1, 3'd4);
        chk("b4_no_done_yet", {31'b0, done4}, 32'd0);
        tick();
        chk("b4_done_pulse", {31'b0, done4}, 32'd1);
        tick();
        chk("b4_iend_crc", do4, 32'hAE426082);
        chk("b4_val", {31'b0, vo4}, 32'd1);

        // nb=0 and nb>4 on a last word both mean a full word
        start(1'b1);
        send(1'b1, 32'h49454E44, 1'b1, 3'd0);
        wait_done(1'b1);
        tick();
        chk("b4_nb0_crc", do4, 32'hAE426082);
        start(1'b1);
        send(1'b1, 32'h49454E44, 1'b1, 3'd7);
        wait_done(1'b1);
        tick();
        chk("b4_nb7_crc", do4, 32'hAE426082);

        // Partial last word with junk in the disabled byte lanes
        start(1'b1);
        send(1'b1, 32'h31323334, 1'b0, 3'd4);
        send(1'b1, 32'h35363738, 1'b0, 3'd4);
        send(1'b1, 32'h39AABBCC, 1'b1, 3'd1);
        wait_done(1'b1);
        tick();
        chk("b4_partial_crc", do4, 32'hCBF43926);

        // Back-pressure: val_i held high across the whole message
        w[0] = 32'h31323334; w[1] = 32'h35363738; w[2] = 32'h39000000;
        start(1'b0);
        val1 = 1'b1; dat = w[0]; lst = 1'b0; nb = 3'd4;
        nacc = 0; ndone = 0;
        for (int c = 0; c < 30; c++) begin
            r = rdy1;
            tick();
            if (done1) ndone++;
            if (r) begin
                if (nacc < 3) acc_cyc[nacc] = c;
                nacc++;
                dat = (nacc < 3) ? w[nacc] : 32'h0;
                lst = (nacc == 2);
                nb  = (nacc == 2) ? 3'd1 : 3'd4;
            end
        end
        val1 = 1'b0;
        chk("bp_accepts", 32'(nacc), 32'd3);
        chk("bp_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd5);
        chk("bp_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd5);
        chk("bp_done_count", 32'(ndone), 32'd1);
        chk("bp_crc", do1, 32'hCBF43926);

        // Abort mid-PROC, then "IEND"; no done_o before the restart completes
        start(1'b0);
        chk("start_clears_val", {31'b0, vo1}, 32'd0);
        chk("dat_kept", do1, 32'hCBF43926);
        send(1'b0, 32'h31323334, 1'b0, 3'd4);
        tick();
        start(1'b0);
        chk("abort_rdy", {31'b0, rdy1}, 32'd1);
        send(1'b0, 32'h49454E44, 1'b1, 3'd4);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_early_done", {31'b0, done1}, 32'd0);
            tick();
        end
        chk("abort_done", {31'b0, done1}, 32'd1);
        tick();
        chk("abort_crc", do1, 32'hAE426082);

        // Reset mid-PROC
        start(1'b0);
        send(1'b0, 32'h31323334, 1'b0, 3'd4);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_rdy", {31'b0, rdy1}, 32'd0);
        chk("rst_done", {31'b0, done1}, 32'd0);
        chk("rst_val", {31'b0, vo1}, 32'd0);
        chk("rst_dat", do1, 32'h0);
        tick(); tick(); tick();
        chk("rst_rdy_held", {31'b0, rdy1}, 32'd0);
        start(1'b0);
        chk("rst_restart_rdy", {31'b0, rdy1}, 32'd1);

`ifdef CRC32_PAR_SEED_EN
        // Continue a CRC across two streams via seed_i
        seed = 32'h0;
        start(1'b0);
        send(1'b0, 32'h31323334, 1'b1, 3'd4);
        wait_done(1'b0);
        tick();
        chk("seed_part1", do1, 32'h9BE3E0A3);
        seed = 32'h9BE3E0A3;
        start(1'b0);
        send(1'b0, 32'h35363738, 1'b0, 3'd4);
        send(1'b0, 32'h39000000, 1'b1, 3'd1);
        wait_done(1'b0);
        tick();
        chk("seed_cont", do1, 32'hCBF43926);
        seed = 32'h0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
